// File: rtl/bcd_seg_pkg.sv
// Shared constants for the seven-segment digit decoder.
// Patterns are active-low in abcdefg order: bit 6 = a ... bit 0 = g.
package bcd_seg_pkg;

  // Segment bit positions inside a pattern word.
  localparam int unsigned SEG_IDX_A = 6;
  localparam int unsigned SEG_IDX_B = 5;
  localparam int unsigned SEG_IDX_C = 4;
  localparam int unsigned SEG_IDX_D = 3;
  localparam int unsigned SEG_IDX_E = 2;
  localparam int unsigned SEG_IDX_F = 1;
  localparam int unsigned SEG_IDX_G = 0;

  // Decimal glyphs.
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

  // Hex glyphs (A, b, C, d, E, F).
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  // Whole-display patterns.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ALL   = 7'b0000000;

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD to active-low segment pattern decoder.
// Define BCD_SEG_HEX_EN to display codes 10-15 as hex glyphs A-F;
// otherwise those codes blank the digit and raise invalid_o.
module bcd_seg_decode
  import bcd_seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] pattern_o,
  output logic       invalid_o
);

  // Map every 4-bit code to a defined pattern; the default covers anything left.
  always_comb begin
    pattern_o = SEG_BLANK;
    invalid_o = 1'b0;
    case (bcd_i)
      4'd0: pattern_o = SEG_0;
      4'd1: pattern_o = SEG_1;
      4'd2: pattern_o = SEG_2;
      4'd3: pattern_o = SEG_3;
      4'd4: pattern_o = SEG_4;
      4'd5: pattern_o = SEG_5;
      4'd6: pattern_o = SEG_6;
      4'd7: pattern_o = SEG_7;
      4'd8: pattern_o = SEG_8;
      4'd9: pattern_o = SEG_9;
`ifdef BCD_SEG_HEX_EN
      4'd10: pattern_o = SEG_A;
      4'd11: pattern_o = SEG_B;
      4'd12: pattern_o = SEG_C;
      4'd13: pattern_o = SEG_D;
      4'd14: pattern_o = SEG_E;
      4'd15: pattern_o = SEG_F;
      default: begin
        pattern_o = SEG_BLANK;
        invalid_o = 1'b1;
      end
`else
      default: begin
        pattern_o = SEG_BLANK;
        invalid_o = 1'b1;
      end
`endif
    endcase
  end

endmodule

// File: rtl/bcd_to_seg.sv
// Registered one-digit BCD to seven-segment driver for a common-anode display.
// lamp_test beats blank, which beats the decoded digit; all act only on load.
// Optional hex glyphs for codes 10-15 are enabled with BCD_SEG_HEX_EN.
module bcd_to_seg
  import bcd_seg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       blank,
  input  logic       lamp_test,
  input  logic [3:0] BCD,
  output logic [6:0] Seg,
  output logic       err
);

  logic [6:0] dec_pattern_s;
  logic       dec_invalid_s;
  logic [6:0] seg_d;
  logic       err_d;
  logic [6:0] seg_q;
  logic       err_q;

  bcd_seg_decode u_decode (
    .bcd_i     (BCD),
    .pattern_o (dec_pattern_s),
    .invalid_o (dec_invalid_s)
  );

  // Override priority: lamp test, then blanking, then the decoded digit.
  always_comb begin
    seg_d = SEG_BLANK;
    err_d = 1'b0;
    if (lamp_test) begin
      seg_d = SEG_ALL;
      err_d = 1'b0;
    end else if (blank) begin
      seg_d = SEG_BLANK;
      err_d = 1'b0;
    end else begin
      seg_d = dec_pattern_s;
      err_d = dec_invalid_s;
    end
  end

  // Output register: reset blanks the digit at once, en gates every load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= SEG_BLANK;
      err_q <= 1'b0;
    end else if (en) begin
      seg_q <= seg_d;
      err_q <= err_d;
    end else begin
      seg_q <= seg_q;
      err_q <= err_q;
    end
  end

  assign Seg = seg_q;
  assign err = err_q;

endmodule

// File: tb/tb_bcd_to_seg.sv
// Self-checking bench for bcd_to_seg: directed scenarios plus random
// stimulus against a behavioural model of the registered display digit.
module tb_bcd_to_seg;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       blank;
  logic       lamp_test;
  logic [3:0] BCD;
  logic [6:0] Seg;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference glyph table (abcdefg, active-low), written from the digit shapes.
  logic [6:0] glyph [0:15];

  // Model of what the display register should hold.
  logic [6:0] exp_seg;
  logic       exp_err;

  bcd_to_seg dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .blank     (blank),
    .lamp_test (lamp_test),
    .BCD       (BCD),
    .Seg       (Seg),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, want);
    end
  endtask

  // What one load should produce from the current inputs.
  task automatic model_load();
    if (lamp_test) begin
      exp_seg = 7'b0000000;
      exp_err = 1'b0;
    end else if (blank) begin
      exp_seg = 7'b1111111;
      exp_err = 1'b0;
    end else if (int'(BCD) <= 9) begin
      exp_seg = glyph[BCD];
      exp_err = 1'b0;
    end else begin
`ifdef BCD_SEG_HEX_EN
      exp_seg = glyph[BCD];
      exp_err = 1'b0;
`else
      exp_seg = 7'b1111111;
      exp_err = 1'b1;
`endif
    end
  endtask

  // Apply inputs, clock once, update the model, then compare away from the edge.
  task automatic step(input string tag, input logic e, input logic b, input logic l,
                      input logic [3:0] code);
    en = e;
    blank = b;
    lamp_test = l;
    BCD = code;
    @(posedge clk);
    if (e) model_load();
    #1;
    check({tag, "_seg"}, Seg, exp_seg);
    check({tag, "_err"}, {6'd0, err}, {6'd0, exp_err});
  endtask

  initial begin
    glyph[0]  = 7'b0000001; glyph[1]  = 7'b1001111; glyph[2]  = 7'b0010010;
    glyph[3]  = 7'b0000110; glyph[4]  = 7'b1001100; glyph[5]  = 7'b0100100;
    glyph[6]  = 7'b0100000; glyph[7]  = 7'b0001111; glyph[8]  = 7'b0000000;
    glyph[9]  = 7'b0000100; glyph[10] = 7'b0001000; glyph[11] = 7'b1100000;
    glyph[12] = 7'b0110001; glyph[13] = 7'b1000010; glyph[14] = 7'b0110000;
    glyph[15] = 7'b0111000;

    // Reset with en=1 and BCD=8, checked before any clock edge.
    rst = 1'b1; en = 1'b1; blank = 1'b0; lamp_test = 1'b0; BCD = 4'd8;
    exp_seg = 7'b1111111; exp_err = 1'b0;
    #1;
    check("rst_now_seg", Seg, 7'b1111111);
    check("rst_now_err", {6'd0, err}, 7'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_seg", Seg, 7'b1111111);
    check("rst_hold_err", {6'd0, err}, 7'd0);
    rst = 1'b0;

    // Sweep every code.
    for (int i = 0; i < 16; i++) step("sweep", 1'b1, 1'b0, 1'b0, 4'(i));

    // Hold: load 3, then en low with a different code.
    step("hold_load", 1'b1, 1'b0, 1'b0, 4'd3);
    check("hold_load_lit", Seg, 7'b0000110);
    step("hold", 1'b0, 1'b0, 1'b0, 4'd7);
    step("hold2", 1'b0, 1'b1, 1'b1, 4'd7);
    check("hold_lit", Seg, 7'b0000110);
    check("hold_err_lit", {6'd0, err}, 7'd0);

    // Overrides.
    step("ovr_blank", 1'b1, 1'b1, 1'b0, 4'd5);
    check("ovr_blank_lit", Seg, 7'b1111111);
    step("ovr_lamp", 1'b1, 1'b1, 1'b1, 4'd5);
    check("ovr_lamp_lit", Seg, 7'b0000000);
    step("ovr_clear", 1'b1, 1'b0, 1'b0, 4'd5);
    check("ovr_clear_lit", Seg, 7'b0100100);

    // Invalid then valid.
    step("inv12", 1'b1, 1'b0, 1'b0, 4'd12);
    step("val9", 1'b1, 1'b0, 1'b0, 4'd9);
    check("val9_lit", Seg, 7'b0000100);
    check("val9_err_lit", {6'd0, err}, 7'd0);

    // Mid-operation reset pulsed between edges.
    step("show2", 1'b1, 1'b0, 1'b0, 4'd2);
    #2 rst = 1'b1;
    #1;
    check("midrst_seg", Seg, 7'b1111111);
    check("midrst_err", {6'd0, err}, 7'd0);
    #1 rst = 1'b0;
    exp_seg = 7'b1111111; exp_err = 1'b0;
    step("restore2", 1'b1, 1'b0, 1'b0, 4'd2);
    check("restore2_lit", Seg, 7'b0010010);

    // Random stimulus against the model.
    for (int i = 0; i < 300; i++) begin
      step("rand",
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 6) == 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
